// File: rtl/imem_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words written to instruction memory from address 0.
// Holds the core in reset until the requested number of words has been written.
module imem_loader #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset_n,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  localparam logic [15:0] MAX_WORDS = 16'(MEM_WORDS);

  state_t      state, state_n;
  logic        error_q, error_n;
  logic [1:0]  byte_idx, byte_idx_n;
  logic [15:0] word_idx, word_idx_n;
  logic [15:0] count_q, count_n;
  logic [23:0] data_buf, data_buf_n;
  logic [31:0] addr_q, addr_n;
  logic [31:0] wdata_q, wdata_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      error_q  <= 1'b0;
      byte_idx <= 2'd0;
      word_idx <= 16'd0;
      count_q  <= 16'd0;
      data_buf <= 24'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
    end else begin
      state    <= state_n;
      error_q  <= error_n;
      byte_idx <= byte_idx_n;
      word_idx <= word_idx_n;
      count_q  <= count_n;
      data_buf <= data_buf_n;
      addr_q   <= addr_n;
      wdata_q  <= wdata_n;
    end
  end

  always_comb begin
    state_n    = state;
    error_n    = error_q;
    byte_idx_n = byte_idx;
    word_idx_n = word_idx;
    count_n    = count_q;
    data_buf_n = data_buf;
    addr_n     = addr_q;
    wdata_n    = wdata_q;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (word_count == 16'd0 || word_count > MAX_WORDS) begin
            error_n = 1'b1;
            state_n = IDLE;
          end else begin
            error_n    = 1'b0;
            count_n    = word_count;
            word_idx_n = 16'd0;
            byte_idx_n = 2'd0;
            state_n    = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (byte_valid) begin
          byte_idx_n = byte_idx + 2'd1;
          case (byte_idx)
            2'd0: data_buf_n[7:0]   = byte_data;
            2'd1: data_buf_n[15:8]  = byte_data;
            2'd2: data_buf_n[23:16] = byte_data;
            default: begin
              // The write port is only updated here so it stays stable outside WRITE.
              wdata_n = {byte_data, data_buf};
              addr_n  = {14'd0, word_idx, 2'b00};
              state_n = WRITE;
            end
          endcase
        end
      end
      WRITE: begin
        if (word_idx == count_q - 16'd1) begin
          state_n = DONE;
        end else begin
          word_idx_n = word_idx + 16'd1;
          byte_idx_n = 2'd0;
          state_n    = COLLECT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign byte_ready  = (state == COLLECT);
  assign mem_we      = (state == WRITE);
  assign busy        = (state == COLLECT) || (state == WRITE);
  assign done        = (state == DONE);
  assign cpu_reset_n = (state == DONE);
  assign error       = error_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized directed bench for imem_loader; expected writes come from a byte-list model packed with plain arithmetic.
module tb_imem_loader;

  localparam int MEM_WORDS = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, mem_we, cpu_reset_n, busy, done, error;
  logic [31:0] mem_addr, mem_wdata;

  imem_loader #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset_n(cpu_reset_n), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_edge = 0;
  int done_cyc = 0;
  bit done_seen = 0;
  bit in_load = 0;
  int busy_drop = 0;

  logic [7:0]  bytes[$];
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];
  int          acc_edges[$];

  always @(posedge clk) cyc++;

  // Labels are the number of the rising edge that opened the observed cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_wdata);
      wq_cyc.push_back(cyc);
    end
    if (byte_valid && byte_ready) acc_edges.push_back(cyc + 1);
    if (done && !done_seen) begin
      done_seen = 1;
      done_cyc  = cyc;
    end
    if (in_load && !done && !busy) busy_drop++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int i);
    int unsigned w;
    w = int'(bytes[4*i]) + int'(bytes[4*i+1]) * 256 + int'(bytes[4*i+2]) * 65536
      + int'(bytes[4*i+3]) * 16777216;
    return 32'(w);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); acc_edges.delete();
    done_seen = 0;
    busy_drop = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_cpu_reset_n"}, {31'd0, cpu_reset_n}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  task automatic issue_start(input int count);
    clear_mon();
    start      = 1'b1;
    word_count = 16'(count);
    start_edge = cyc + 1;
    tick();
    start   = 1'b0;
    in_load = 1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    got = 0;
    repeat (gap) begin
      byte_valid = 1'b0;
      tick();
    end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      got = byte_ready;
      tick();
      if (got) break;
    end
    byte_valid = 1'b0;
    if (!got) chk("byte_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic wait_done();
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_reached", {31'd0, done}, 32'd1);
    in_load = 0;
    tick();
  endtask

  task automatic run_load(input int count, input int gap);
    issue_start(count);
    for (int i = 0; i < count * 4; i++) send_byte(bytes[i], gap);
    wait_done();
  endtask

  task automatic chk_writes(input string tag, input int n);
    chk({tag, "_nwrites"}, 32'(wq_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wq_addr.size(); i++) begin
      chk({tag, "_addr"}, wq_addr[i], 32'(4 * i));
      chk({tag, "_data"}, wq_data[i], model_word(i));
    end
  endtask

  task automatic fill_random(input int n);
    bytes.delete();
    for (int i = 0; i < n; i++) bytes.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic bad_start(input string tag, input int count);
    issue_start(count);
    in_load = 0;
    @(negedge clk);
    chk({tag, "_error"}, {31'd0, error}, 32'd1);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_cpu_reset_n"}, {31'd0, cpu_reset_n}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    repeat (5) tick();
    chk({tag, "_no_write"}, 32'(wq_addr.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; word_count = 16'd0;
    byte_valid = 1'b0; byte_data = 8'd0;
    repeat (3) tick();
    chk_reset_vals("reset");
    reset = 1'b1;
    tick();

    // Basic load with the fixed program words.
    bytes = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(2, 0);
    chk_writes("basic", 2);
    chk("basic_word0_const", model_word(0), 32'h0000_0013);
    chk("basic_word1_const", model_word(1), 32'h0010_0093);
    if (acc_edges.size() > 0) chk("basic_first_accept", 32'(acc_edges[0]), 32'(start_edge + 1));
    if (wq_cyc.size() >= 2) begin
      chk("basic_we0_edge", 32'(wq_cyc[0]), 32'(start_edge + 4));
      chk("basic_word_spacing", 32'(wq_cyc[1] - wq_cyc[0]), 32'd5);
      chk("basic_done_edge", 32'(done_cyc), 32'(wq_cyc[1] + 1));
    end
    chk("basic_cpu_reset_n", {31'd0, cpu_reset_n}, 32'd1);
    chk("basic_byte_ready", {31'd0, byte_ready}, 32'd0);
    // Bytes offered in DONE must not be consumed.
    byte_valid = 1'b1;
    repeat (3) tick();
    byte_valid = 1'b0;
    chk("done_no_accept", 32'(acc_edges.size()), 32'd8);

    bad_start("cnt_zero", 0);
    bad_start("cnt_over", MEM_WORDS + 1);

    // Stalled stream; also the valid start that clears error.
    fill_random(4);
    issue_start(1);
    @(negedge clk);
    chk("clear_error", {31'd0, error}, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) send_byte(bytes[i], 3);
    wait_done();
    chk_writes("stall", 1);
    chk("stall_naccept", 32'(acc_edges.size()), 32'd4);
    if (acc_edges.size() >= 2) chk("stall_accept_gap", 32'(acc_edges[1] - acc_edges[0]), 32'd4);
    chk("stall_busy_held", 32'(busy_drop), 32'd0);

    // Full memory with incrementing bytes.
    bytes.delete();
    for (int i = 0; i < MEM_WORDS * 4; i++) bytes.push_back(8'(i));
    run_load(MEM_WORDS, 0);
    repeat (5) tick();
    chk_writes("full", MEM_WORDS);
    if (wq_addr.size() > 0) chk("full_last_addr", wq_addr[wq_addr.size() - 1], 32'((MEM_WORDS - 1) * 4));

    // Reset in the middle of word 1.
    fill_random(8);
    issue_start(2);
    for (int i = 0; i < 6; i++) send_byte(bytes[i], $urandom_range(0, 2));
    in_load = 0;
    reset = 1'b0;
    #2;
    chk_reset_vals("midreset");
    tick();
    reset = 1'b1;
    repeat (10) tick();
    chk_writes("midreset", 1);
    chk("midreset_idle_busy", {31'd0, busy}, 32'd0);
    fill_random(4);
    run_load(1, $urandom_range(0, 2));
    chk_writes("after_reset", 1);

    // Reload straight from DONE.
    fill_random(4);
    issue_start(1);
    @(negedge clk);
    chk("reload_done_low", {31'd0, done}, 32'd0);
    chk("reload_cpu_reset", {31'd0, cpu_reset_n}, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) send_byte(bytes[i], $urandom_range(0, 1));
    wait_done();
    chk_writes("reload", 1);

    // Random multi-word loads.
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(1, 6);
      fill_random(n * 4);
      run_load(n, $urandom_range(0, 2));
      chk_writes("rand", n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
